// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the timer compare/interrupt peripheral.
package timer_pkg;

  localparam logic [1:0] ADDR_COMPARE = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_PERIOD  = 2'd3;

  localparam int unsigned CTRL_CMP_EN    = 0;
  localparam int unsigned CTRL_IRQ_EN    = 1;
  localparam int unsigned CTRL_RELOAD_EN = 2;

  localparam int unsigned STAT_PENDING = 0;
  localparam int unsigned STAT_OVERRUN = 1;

endpackage

// File: rtl/timer_compare_irq_if.sv
// Bus bundle between the CPU/timer side (master) and the compare peripheral (slave).
interface timer_compare_irq_if;

  logic [31:0] counterIn;
  logic        chipSelect;
  logic        write;
  logic [1:0]  address;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        irq;

  modport master (
    output counterIn, chipSelect, write, address, dataIn,
    input  dataOut, irq
  );

  modport slave (
    input  counterIn, chipSelect, write, address, dataIn,
    output dataOut, irq
  );

endinterface

// File: rtl/timer_compare_irq.sv
// Compares the live timer count against COMPARE and raises a level interrupt on the first
// cycle of equality. Define TIMER_CMP_RELOAD_EN to enable the PERIOD auto-reload feature.
module timer_compare_irq
  import timer_pkg::*;
#(
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input logic               clk,
  input logic               rst,
  timer_compare_irq_if.slave bus
);

  logic [31:0] compare_q, compare_d;
  logic [31:0] prev_q;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic        wr;
  logic        match;
  logic        clr_pending;
  logic        clr_overrun;
`ifdef TIMER_CMP_RELOAD_EN
  logic [31:0] period_q, period_d;
`endif

  always_comb begin
    wr    = bus.chipSelect & bus.write;
    // Previous-cycle inequality makes a held count match only once.
    match = ctrl_q[CTRL_CMP_EN] & (bus.counterIn == compare_q) & (prev_q != compare_q);

    clr_pending = wr & (bus.address == ADDR_STATUS) & bus.dataIn[STAT_PENDING];
    clr_overrun = wr & (bus.address == ADDR_STATUS) & bus.dataIn[STAT_OVERRUN];

    compare_d = compare_q;
`ifdef TIMER_CMP_RELOAD_EN
    period_d = period_q;
    if (wr && (bus.address == ADDR_PERIOD)) period_d = bus.dataIn;
    if (match && ctrl_q[CTRL_RELOAD_EN] && (period_q != '0)) compare_d = compare_q + period_q;
`endif
    // Software write takes priority over the reload.
    if (wr && (bus.address == ADDR_COMPARE)) compare_d = bus.dataIn;

    ctrl_d = ctrl_q;
    if (wr && (bus.address == ADDR_CTRL)) begin
`ifdef TIMER_CMP_RELOAD_EN
      ctrl_d = bus.dataIn[2:0];
`else
      ctrl_d = {1'b0, bus.dataIn[1:0]};
`endif
    end

    // A set in the same cycle as a clear wins.
    pending_d = match | (pending_q & ~clr_pending);
    overrun_d = (match & pending_q) | (overrun_q & ~clr_overrun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      compare_q <= RESET_COMPARE;
      ctrl_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      prev_q    <= '0;
`ifdef TIMER_CMP_RELOAD_EN
      period_q  <= '0;
`endif
    end else begin
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      prev_q    <= bus.counterIn;
`ifdef TIMER_CMP_RELOAD_EN
      period_q  <= period_d;
`endif
    end
  end

  always_comb begin
    bus.dataOut = '0;
    unique case (bus.address)
      ADDR_COMPARE: bus.dataOut = compare_q;
      ADDR_CTRL:    bus.dataOut = {29'd0, ctrl_q};
      ADDR_STATUS:  bus.dataOut = {30'd0, overrun_q, pending_q};
`ifdef TIMER_CMP_RELOAD_EN
      ADDR_PERIOD:  bus.dataOut = period_q;
`else
      ADDR_PERIOD:  bus.dataOut = '0;
`endif
    endcase
    bus.irq = pending_q & ctrl_q[CTRL_IRQ_EN];
  end

endmodule

// File: tb/tb_timer_compare_irq.sv
// Self-checking bench for timer_compare_irq: constant vector table, directed corner cases and
// randomized traffic against a behavioural model.
module tb_timer_compare_irq;

`ifdef TIMER_CMP_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timer_compare_irq_if bus ();

  timer_compare_irq #(
    .RESET_COMPARE(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_cmp, m_prev, m_per;
  logic [2:0]  m_ctrl;
  bit          m_pend, m_ovr;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_cmp;
      2'd1:    return {29'd0, m_ctrl};
      2'd2:    return {30'd0, m_ovr, m_pend};
      default: return m_per;
    endcase
  endfunction

  function automatic void model_clock(input bit r, input bit cs, input bit we,
                                      input logic [1:0] a, input logic [31:0] d,
                                      input logic [31:0] c);
    bit hit, wr;
    logic [31:0] n_cmp;
    if (r) begin
      m_cmp = 32'hFFFF_FFFF; m_ctrl = '0; m_pend = 0; m_ovr = 0; m_prev = '0; m_per = '0;
      return;
    end
    hit = m_ctrl[0] && (c == m_cmp) && (m_prev != m_cmp);
    wr  = cs && we;
    n_cmp = m_cmp;
    if (hit && RELOAD && m_ctrl[2] && m_per != 0) n_cmp = m_cmp + m_per;
    if (wr && a == 2'd0) n_cmp = d;
    if (wr && a == 2'd1) m_ctrl = RELOAD ? d[2:0] : {1'b0, d[1:0]};
    if (wr && a == 2'd3 && RELOAD) m_per = d;
    if (hit && m_pend) m_ovr = 1;
    else if (wr && a == 2'd2 && d[1]) m_ovr = 0;
    if (hit) m_pend = 1;
    else if (wr && a == 2'd2 && d[0]) m_pend = 0;
    m_cmp  = n_cmp;
    m_prev = c;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample/check before posedge, advance the model at posedge.
  task automatic step(input bit r, input bit cs, input bit we, input logic [1:0] a,
                      input logic [31:0] d, input logic [31:0] c,
                      output logic [31:0] so, output logic si);
    rst            = r;
    bus.chipSelect = cs;
    bus.write      = we;
    bus.address    = a;
    bus.dataIn     = d;
    bus.counterIn  = c;
    #1;
    so = bus.dataOut;
    si = bus.irq;
    check("model_dout", so, model_read(a));
    check("model_irq", {31'd0, si}, {31'd0, m_pend & m_ctrl[1]});
    @(posedge clk);
    model_clock(r, cs, we, a, d, c);
    @(negedge clk);
  endtask

  typedef struct {
    bit          cs, we;
    logic [1:0]  addr;
    logic [31:0] din, cnt, exp_dout;
    bit          exp_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic void rd(input logic [1:0] a, input logic [31:0] c,
                             input logic [31:0] ed, input bit ei);
    vecs.push_back('{cs: 1'b1, we: 1'b0, addr: a, din: 32'd0, cnt: c, exp_dout: ed, exp_irq: ei});
  endfunction

  function automatic void wrv(input logic [1:0] a, input logic [31:0] d, input logic [31:0] c,
                              input logic [31:0] ed, input bit ei);
    vecs.push_back('{cs: 1'b1, we: 1'b1, addr: a, din: d, cnt: c, exp_dout: ed, exp_irq: ei});
  endfunction

  logic [31:0] so;
  logic        si;

  initial begin
    int hits;
    logic [31:0] cnt;
    bus.chipSelect = 0; bus.write = 0; bus.address = 0; bus.dataIn = 0; bus.counterIn = 0;
    model_clock(1'b1, 0, 0, 2'd0, 0, 0);
    @(negedge clk);
    step(1, 0, 0, 2'd0, 0, 0, so, si);

    // Reset values, single match on a held count, overrun, W1C and clear/set collision
    rd(2'd0, 0, 32'hFFFF_FFFF, 0);
    rd(2'd1, 0, 0, 0);
    rd(2'd2, 0, 0, 0);
    rd(2'd3, 0, 0, 0);
    wrv(2'd0, 5, 0, 32'hFFFF_FFFF, 0);
    wrv(2'd1, 3, 0, 0, 0);
    rd(2'd2, 5, 0, 0);
    for (int k = 0; k < 63; k++) rd(2'd2, 5, 1, 1);
    rd(2'd2, 6, 1, 1);
    rd(2'd2, 5, 1, 1);
    rd(2'd2, 5, 3, 1);
    wrv(2'd2, 1, 5, 3, 1);
    rd(2'd2, 5, 2, 0);
    wrv(2'd2, 2, 5, 2, 0);
    rd(2'd2, 5, 0, 0);
    rd(2'd2, 6, 0, 0);
    rd(2'd2, 5, 0, 0);
    rd(2'd2, 6, 1, 1);
    wrv(2'd2, 1, 5, 1, 1);
    rd(2'd2, 5, 3, 1);
    rd(2'd0, 5, 5, 1);
    wrv(2'd2, 3, 5, 3, 1);
    rd(2'd2, 5, 0, 0);

    foreach (vecs[i]) begin
      step(0, vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].cnt, so, si);
      check($sformatf("vec%0d_dout", i), so, vecs[i].exp_dout);
      check($sformatf("vec%0d_irq", i), {31'd0, si}, {31'd0, vecs[i].exp_irq});
    end

    // Periodic reload sweep; status cleared every cycle so each match shows up once
    step(1, 0, 0, 2'd0, 0, 0, so, si);
    step(0, 1, 1, 2'd0, 10, 0, so, si);
    step(0, 1, 1, 2'd3, 10, 0, so, si);
    step(0, 1, 1, 2'd1, 7, 0, so, si);
    hits = 0;
    for (int c = 0; c <= 35; c++) begin
      step(0, 1, 1, 2'd2, 3, c, so, si);
      if (so[0]) hits++;
    end
    step(0, 1, 0, 2'd2, 0, 35, so, si);
    if (so[0]) hits++;
    check("reload_matches", hits, RELOAD ? 32'd3 : 32'd1);
    step(0, 1, 0, 2'd0, 0, 35, so, si);
    check("reload_compare", so, RELOAD ? 32'd40 : 32'd10);
    step(0, 1, 0, 2'd1, 0, 35, so, si);
    check("reload_ctrl", so, RELOAD ? 32'd7 : 32'd3);

    // Wrap through 0xFFFFFFFF, then reset while irq is high
    step(1, 0, 0, 2'd0, 0, 0, so, si);
    step(0, 1, 1, 2'd1, 3, 32'hFFFF_FFFE, so, si);
    step(0, 1, 0, 2'd2, 0, 32'hFFFF_FFFF, so, si);
    check("wrap_premature", so, 0);
    step(0, 1, 0, 2'd2, 0, 32'h0, so, si);
    check("wrap_status", so, 1);
    check("wrap_irq", {31'd0, si}, 32'd1);
    step(0, 1, 0, 2'd2, 0, 32'h1, so, si);
    check("wrap_once", so, 1);
    step(1, 1, 0, 2'd2, 0, 32'h1, so, si);
    check("rst_irq_before", {31'd0, si}, 32'd1);
    step(0, 1, 0, 2'd0, 0, 32'h1, so, si);
    check("rst_irq_after", {31'd0, si}, 32'd0);
    check("rst_compare", so, 32'hFFFF_FFFF);
    step(0, 1, 0, 2'd1, 0, 32'h1, so, si);
    check("rst_ctrl", so, 0);
    step(0, 1, 0, 2'd2, 0, 32'h1, so, si);
    check("rst_status", so, 0);
    step(0, 1, 0, 2'd3, 0, 32'h1, so, si);
    check("rst_period", so, 0);

    // Randomized traffic against the model, small value range to provoke matches
    cnt = 0;
    for (int n = 0; n < 600; n++) begin
      bit r, cs, we;
      logic [1:0] a;
      logic [31:0] d;
      r  = ($urandom_range(0, 79) == 0);
      cs = $urandom_range(0, 1);
      we = $urandom_range(0, 1);
      a  = 2'($urandom_range(0, 3));
      case (a)
        2'd0:    d = $urandom_range(0, 7);
        2'd3:    d = $urandom_range(0, 3);
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 2) != 0) cnt = $urandom_range(0, 7);
      step(r, cs, we, a, d, cnt, so, si);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
